radix2_signed_divider: RTL and testbench
========================================

# radix2_signed_divider

Sequential signed integer divider, the inverse of the radix-4 Booth multiplier in the arithmetic block set. Accepts a dividend/divisor pair on a start pulse and produces quotient and remainder via a restoring radix-2 algorithm, one quotient bit per enabled clock. Truncates toward zero; the remainder takes the dividend's sign. Feeds the same register-wrapped datapath as the multiplier, and a multiplier product divided here recovers the original operand.

## Interface

- WIDTH, 32, operand/result width in bits (≥ 4)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- en  input  1  clock enable; when low all state and outputs hold
- start  input  1  request; sampled only in IDLE with en=1
- a  input  WIDTH  signed dividend, captured when start is accepted
- b  input  WIDTH  signed divisor, captured when start is accepted
- busy  output  1  high from the accepting edge until done is asserted
- done  output  1  one-cycle pulse; quotient/remainder valid
- quotient  output  WIDTH  signed quotient, held until next done
- remainder  output  WIDTH  signed remainder, held until next done
- div_by_zero  output  1  set with done when b was 0; cleared at next accept

## Operation

- States: IDLE, RUN, FIX.
- IDLE: on start=1 and en=1, capture |a|, |b| as WIDTH-bit unsigned magnitudes (most-negative value maps to 2^(WIDTH-1)), sign_q = a[MSB]^b[MSB], sign_r = a[MSB]; clear partial remainder, iteration counter to 0; busy=1; clear div_by_zero; go to RUN. If b=0, go directly to FIX with a zero-divisor flag.
- RUN: per enabled edge, shift {partial remainder, dividend} left by 1; trial-subtract divisor from the (WIDTH+1)-bit partial remainder; if non-negative keep difference and shift in quotient bit 1, else restore and shift in 0. After WIDTH iterations go to FIX.
- FIX: quotient = sign_q ? −q : q, remainder = sign_r ? −r : r, both truncated to WIDTH bits; done=1 for one cycle; busy=0; return to IDLE.
- Divide-by-zero: quotient = all ones (−1), remainder = a unchanged, div_by_zero=1.
- Overflow (most-negative ÷ −1): quotient = most-negative value (wraps), remainder = 0, div_by_zero=0. No flag.
- start while busy is ignored; no queueing.
- en=0 freezes state, counter, and outputs (done stays asserted if it was set).

## Timing

- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, state IDLE. Reset takes priority over en and aborts any operation in flight; no done is produced for it.
- Edge E0 accepts start. E1..E_WIDTH perform the iterations. E_(WIDTH+1) registers the results and sets done. E_(WIDTH+2) clears done.
- Latency is WIDTH+1 enabled cycles (33 for WIDTH=32). Each en=0 cycle adds one cycle.
- Divide-by-zero: done at E1, a latency of 1 cycle.
- A new start is accepted at the same edge that clears done (the cycle after the done pulse), giving a back-to-back throughput of one result per WIDTH+2 cycles.
- Outputs are registers only; there is no combinational input-to-output path.

## Test plan

- a=464960160, b=840, start pulse → done exactly 33 cycles later; quotient=553524, remainder=0, busy high for cycles 1–32.
- Sign matrix, WIDTH=32:
  - −7/2 → q=−3, r=−1
  - 7/−2 → q=−3, r=1
  - −7/−2 → q=3, r=−1
  - −143362716/553524 → q=−259, r=0
- Boundaries:
  - a=32'h80000000, b=−1 → q=32'h80000000, r=0, div_by_zero=0
  - a=32'h80000000, b=1 → q=32'h80000000
  - a=0, b=5 → q=0, r=0
- Divide-by-zero: a=−1199060305, b=0 → done after 1 cycle, q=32'hFFFFFFFF, r=−1199060305, div_by_zero=1. The next valid op clears the flag.
- Handshake:
  - A second start with new operands at cycle 10 is ignored; the first result is unchanged.
  - Holding en=0 for 5 cycles mid-RUN makes done arrive at cycle 38, with a correct result.
- Reset (reset=0) at cycle 15 of an op → all outputs 0 the next cycle and no done. A fresh 100/7 then gives q=14, r=2.

Source files
------------

// File: rtl/radix2_signed_divider_if.sv
// Request/result bundle for the sequential signed divider.
// The master issues operands and start; the slave returns quotient, remainder and status.
interface radix2_signed_divider_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output en, start, a, b,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  en, start, a, b,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/radix2_signed_divider.sv
// Restoring radix-2 signed divider: one quotient bit per enabled clock, truncating toward zero.
// The remainder follows the dividend's sign; a zero divisor gives q=-1, r=a and a flag.
module radix2_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_i,   // synchronous, active-low
    radix2_signed_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;         // partial remainder (always < divisor)
    logic [WIDTH-1:0] dvd_q, dvd_d;         // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_div_q, zero_div_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] quo_mag;
    logic [WIDTH-1:0] rem_mag;

    // Two's-complement negation maps the most-negative value onto 2^(WIDTH-1) unsigned.
    assign abs_a = bus.a[WIDTH-1] ? ('0 - bus.a) : bus.a;
    assign abs_b = bus.b[WIDTH-1] ? ('0 - bus.b) : bus.b;

    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    // On a zero divisor the dividend magnitude is still in dvd_q, so re-signing it returns a.
    assign quo_mag = dvd_q;
    assign rem_mag = zero_div_q ? dvd_q : rem_q;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        cnt_d      = cnt_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        zero_div_d = zero_div_q;
        busy_d     = busy_q;
        done_d     = done_q;
        quo_out_d  = quo_out_q;
        rem_out_d  = rem_out_q;
        dbz_d      = dbz_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (bus.start) begin
                    dvd_d      = abs_a;
                    dvs_d      = abs_b;
                    rem_d      = '0;
                    cnt_d      = '0;
                    neg_quo_d  = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                    neg_rem_d  = bus.a[WIDTH-1];
                    zero_div_d = (bus.b == '0);
                    busy_d     = 1'b1;
                    dbz_d      = 1'b0;
                    state_d    = (bus.b == '0) ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                if (trial[WIDTH]) begin
                    rem_d = shifted[WIDTH-1:0];
                end else begin
                    rem_d = trial[WIDTH-1:0];
                end
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (zero_div_q) begin
                    quo_out_d = '1;
                end else begin
                    quo_out_d = neg_quo_q ? ('0 - quo_mag) : quo_mag;
                end
                rem_out_d = neg_rem_q ? ('0 - rem_mag) : rem_mag;
                dbz_d     = zero_div_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_div_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quo_out_q  <= '0;
            rem_out_q  <= '0;
            dbz_q      <= 1'b0;
        end else if (bus.en) begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            cnt_q      <= cnt_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            zero_div_q <= zero_div_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quo_out_q  <= quo_out_d;
            rem_out_q  <= rem_out_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quo_out_q;
    assign bus.remainder   = rem_out_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_radix2_signed_divider.sv
// Directed-vector bench for radix2_signed_divider (WIDTH=32) with hand-computed results.
module tb_radix2_signed_divider;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    radix2_signed_divider_if #(.WIDTH(32)) bus ();

    radix2_signed_divider #(.WIDTH(32)) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Counts cycles after the accepting edge until done; busy must stay high meanwhile.
    task automatic wait_done(output int n, output bit busy_ok);
        n = 0;
        busy_ok = 1'b1;
        while (n < 200) begin
            tick();
            n++;
            if (bus.done) break;
            if (!bus.busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input logic exp_dz, input int exp_lat);
        int n;
        bit busy_ok;
        start_op(a, b);
        wait_done(n, busy_ok);
        check_eq({tag, "_lat"}, 64'(n), 64'(exp_lat));
        check_eq({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
        check_eq({tag, "_q"}, {32'd0, bus.quotient}, {32'd0, exp_q});
        check_eq({tag, "_r"}, {32'd0, bus.remainder}, {32'd0, exp_r});
        check_eq({tag, "_dz"}, {63'd0, bus.div_by_zero}, {63'd0, exp_dz});
        $display("op %s: a=%0d b=%0d q=%0d r=%0d dz=%0b lat=%0d", tag, $signed(a), $signed(b),
                 $signed(bus.quotient), $signed(bus.remainder), bus.div_by_zero, n);
    endtask

    initial begin
        int  n;
        int  done_seen;
        bit  busy_ok;

        bus.en    = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) tick();
        check_eq("rst_busy", {63'd0, bus.busy}, 64'd0);
        check_eq("rst_done", {63'd0, bus.done}, 64'd0);
        check_eq("rst_q", {32'd0, bus.quotient}, 64'd0);
        check_eq("rst_r", {32'd0, bus.remainder}, 64'd0);
        check_eq("rst_dz", {63'd0, bus.div_by_zero}, 64'd0);
        reset_n = 1'b1;
        tick();

        run_div("main", 32'd464960160, 32'd840, 32'd553524, 32'd0, 1'b0, 33);
        run_div("m7d2", -32'sd7, 32'sd2, -32'sd3, -32'sd1, 1'b0, 33);
        run_div("p7dm2", 32'sd7, -32'sd2, -32'sd3, 32'sd1, 1'b0, 33);
        run_div("m7dm2", -32'sd7, -32'sd2, 32'sd3, -32'sd1, 1'b0, 33);
        run_div("big_neg", -32'sd143362716, 32'sd553524, -32'sd259, 32'sd0, 1'b0, 33);
        run_div("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_div("minby1", 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 33);
        run_div("dbz", -32'sd1199060305, 32'd0, 32'hFFFF_FFFF, -32'sd1199060305, 1'b1, 1);

        // The next accepted operation must clear the zero-divisor flag at its accepting edge.
        start_op(32'd0, 32'd5);
        check_eq("dz_clear", {63'd0, bus.div_by_zero}, 64'd0);
        wait_done(n, busy_ok);
        check_eq("zero_lat", 64'(n), 64'd34 - 64'd1);
        check_eq("zero_q", {32'd0, bus.quotient}, 64'd0);
        check_eq("zero_r", {32'd0, bus.remainder}, 64'd0);
        $display("op zero: q=%0d r=%0d lat=%0d", $signed(bus.quotient), $signed(bus.remainder), n);

        // A start while busy is ignored.
        start_op(32'd464960160, 32'd840);
        repeat (9) tick();
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n, busy_ok);
        check_eq("ign_lat", 64'(n + 10), 64'd33);
        check_eq("ign_q", {32'd0, bus.quotient}, 64'd553524);
        check_eq("ign_r", {32'd0, bus.remainder}, 64'd0);
        $display("op ignore2nd: q=%0d r=%0d lat=%0d", $signed(bus.quotient), $signed(bus.remainder), n + 10);

        // en low for 5 cycles mid-RUN stretches latency to 38.
        start_op(-32'sd7, 32'sd2);
        repeat (10) tick();
        bus.en = 1'b0;
        repeat (5) tick();
        bus.en = 1'b1;
        wait_done(n, busy_ok);
        check_eq("en_lat", 64'(n + 15), 64'd38);
        check_eq("en_q", {32'd0, bus.quotient}, {32'd0, -32'sd3});
        check_eq("en_r", {32'd0, bus.remainder}, {32'd0, -32'sd1});
        $display("op en_gap: q=%0d r=%0d lat=%0d", $signed(bus.quotient), $signed(bus.remainder), n + 15);
        bus.en = 1'b0;
        repeat (3) tick();
        check_eq("done_hold", {63'd0, bus.done}, 64'd1);
        bus.en = 1'b1;
        tick();
        check_eq("done_clr", {63'd0, bus.done}, 64'd0);

        // Reset mid-operation aborts it with no done.
        start_op(32'd464960160, 32'd840);
        repeat (14) tick();
        reset_n = 1'b0;
        tick();
        check_eq("abort_busy", {63'd0, bus.busy}, 64'd0);
        check_eq("abort_done", {63'd0, bus.done}, 64'd0);
        check_eq("abort_q", {32'd0, bus.quotient}, 64'd0);
        check_eq("abort_r", {32'd0, bus.remainder}, 64'd0);
        check_eq("abort_dz", {63'd0, bus.div_by_zero}, 64'd0);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check_eq("abort_nodone", 64'(done_seen), 64'd0);
        $display("op reset_abort: done_seen=%0d", done_seen);
        run_div("d100by7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
